sel_frecuencias_param: RTL

Parametrised, button-controlled square-wave frequency generator, the successor to the fixed-step frequency selector on the Nexys board. Two push-button inputs step a frequency index up or down through NUM_SEL octave steps. The block includes on-board synchronisation, debouncing and edge detection, optional wrap-around and an output enable. Frequency changes are glitch-free and take effect only at a half-period boundary. The output feeds the board-level tone/LED driver.

---
 rtl/sel_frecuencias_param.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sel_frecuencias_param.sv
// Button-stepped square-wave generator: synchronised, debounced up/down buttons
// move an octave index; the half-period reloads only at a toggle boundary.
module sel_frecuencias_param #(
  parameter int CNT_W     = 24,
  parameter int NUM_SEL   = 8,
  parameter int SEL_W     = 3,
  parameter int BASE_HALF = 25000,
  parameter int SEL_INIT  = 0,
  parameter int DEB_CYC   = 250000,
  parameter int WRAP      = 0
) (
  input  logic             clknexys,
  input  logic             Reset,
  input  logic             aumf_i,
  input  logic             bajaf_i,
  input  logic             en_i,
  output logic             salida_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             limite_o
);

  localparam int               DEB_W     = $clog2(DEB_CYC + 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYC);
  localparam logic [DEB_W-1:0] DEB_ONE   = DEB_W'(1);
  localparam logic [SEL_W-1:0] SEL_MAX   = SEL_W'(NUM_SEL - 1);
  localparam logic [SEL_W-1:0] SEL_RST   = SEL_W'(SEL_INIT);
  localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);
  localparam logic [CNT_W-1:0] HALF_BASE = CNT_W'(BASE_HALF);
  localparam logic [CNT_W-1:0] HALF_RST  = HALF_BASE << (NUM_SEL - 1 - SEL_INIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic             LIM_RST   = (SEL_INIT == 0) || (SEL_INIT == NUM_SEL - 1);

  // Bit 0 is the "up" button, bit 1 the "down" button.
  logic [1:0]            btn;
  logic [1:0]            sync_a;
  logic [1:0]            sync_b;
  logic [1:0]            deb;
  logic [1:0]            deb_q;
  logic [1:0][DEB_W-1:0] deb_cnt;

  logic                  pulse_up;
  logic                  pulse_dn;
  logic [SEL_W-1:0]      sel_next;
  logic                  limite_next;

  logic [CNT_W-1:0]      half_req;
  logic [CNT_W-1:0]      half_act;
  logic [CNT_W-1:0]      cnt;

  assign btn = {bajaf_i, aumf_i};

  // The counter only runs while the synchronised level disagrees with the
  // accepted one, so any return to the old level restarts the stability window.
  always_ff @(posedge clknexys or negedge Reset) begin
    if (!Reset) begin
      sync_a  <= '0;
      sync_b  <= '0;
      deb     <= '0;
      deb_q   <= '0;
      deb_cnt <= '0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      deb_q  <= deb;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync_b[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync_b[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_ONE;
        end
      end
    end
  end

  assign pulse_up = deb[0] & ~deb_q[0];
  assign pulse_dn = deb[1] & ~deb_q[1];

  always_comb begin
    sel_next = sel_o;
    if (pulse_up && !pulse_dn) begin
      if (sel_o == SEL_MAX) begin
        if (WRAP != 0) sel_next = '0;
      end else begin
        sel_next = sel_o + SEL_ONE;
      end
    end else if (pulse_dn && !pulse_up) begin
      if (sel_o == '0) begin
        if (WRAP != 0) sel_next = SEL_MAX;
      end else begin
        sel_next = sel_o - SEL_ONE;
      end
    end
    limite_next = (sel_next == '0) || (sel_next == SEL_MAX);
  end

  always_ff @(posedge clknexys or negedge Reset) begin
    if (!Reset) begin
      sel_o    <= SEL_RST;
      limite_o <= LIM_RST;
    end else begin
      sel_o    <= sel_next;
      limite_o <= limite_next;
    end
  end

  assign half_req = HALF_BASE << (SEL_MAX - sel_o);

  // half_act is captured only at a toggle (or while disabled), so an index
  // change never alters the half-period already in progress.
  always_ff @(posedge clknexys or negedge Reset) begin
    if (!Reset) begin
      salida_o <= 1'b0;
      cnt      <= '0;
      half_act <= HALF_RST;
    end else if (!en_i) begin
      salida_o <= 1'b0;
      cnt      <= '0;
      half_act <= half_req;
    end else if (cnt == half_act - CNT_ONE) begin
      salida_o <= ~salida_o;
      cnt      <= '0;
      half_act <= half_req;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule
